// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared state encoding and arithmetic helpers
// for the run-control / watchdog unit.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } state_t;

  localparam int SAT_W = 64;

  // Widest counter supported is SAT_W; callers cast in and out.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input logic [SAT_W-1:0] lim
  );
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, lim}) return lim;
    return s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/run_monitor_trap_arbiter.sv
// trap_arbiter: picks the lowest-index trapping core and
// forwards its result word.
module trap_arbiter #(
  parameter  int NCORES = 1,
  parameter  int XLEN   = 32,
  localparam int IW     = $clog2(NCORES > 1 ? NCORES : 2)
) (
  input  logic [NCORES-1:0]      trap,
  input  logic [NCORES*XLEN-1:0] result,
  output logic                   any,
  output logic [IW-1:0]          index,
  output logic [XLEN-1:0]        sel
);

  always_comb begin
    any   = |trap;
    index = '0;
    sel   = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (trap[i]) begin
        index = IW'(i);
        sel   = result[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: sequences core reset, counts run cycles and
// retired instructions, stops on first trap or timeout.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter  int NCORES       = 1,
  parameter  int XLEN         = 32,
  parameter  int CNT_W        = 32,
  parameter  int RESET_CYCLES = 4,
  parameter  int TIMEOUT      = 5000,
  localparam int IW           = $clog2(NCORES > 1 ? NCORES : 2)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [NCORES-1:0]      trap,
  input  logic [NCORES-1:0]      step,
  input  logic [NCORES*XLEN-1:0] result,
  output logic [NCORES-1:0]      core_resetn,
  output logic                   busy,
  output logic                   done,
  output logic                   timed_out,
  output logic [IW-1:0]          trap_core,
  output logic [XLEN-1:0]        trap_result,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt
);

  localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  localparam int PW = $clog2(NCORES + 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);
  localparam logic [RW-1:0]    RLAST = RW'(RESET_CYCLES - 1);

  state_t          state;
  logic [RW-1:0]   rcnt;
  logic [PW-1:0]   pc;
  logic            any;
  logic [IW-1:0]   idx;
  logic [XLEN-1:0] sel;

  trap_arbiter #(
    .NCORES (NCORES),
    .XLEN   (XLEN)
  ) u_arb (
    .trap   (trap),
    .result (result),
    .any    (any),
    .index  (idx),
    .sel    (sel)
  );

  always_comb pc = PW'($countones(step));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rcnt        <= '0;
      core_resetn <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      trap_core   <= '0;
      trap_result <= '0;
      cycle_cnt   <= '0;
      retire_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RESET;
            rcnt        <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            trap_core   <= '0;
            trap_result <= '0;
            cycle_cnt   <= '0;
            retire_cnt  <= '0;
          end
        end
        RESET: begin
          if (rcnt == RLAST) begin
            state       <= RUN;
            core_resetn <= '1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RUN: begin
          cycle_cnt  <= CNT_W'(sat_add(SAT_W'(cycle_cnt),
                                       SAT_W'(1),
                                       SAT_W'(CMAX)));
          retire_cnt <= CNT_W'(sat_add(SAT_W'(retire_cnt),
                                       SAT_W'(pc),
                                       SAT_W'(CMAX)));
          // A trap in the timeout cycle takes precedence.
          if (any || (TIMEOUT != 0 && cycle_cnt == TLAST)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            core_resetn <= '0;
            if (any) begin
              trap_core   <= idx;
              trap_result <= sel;
            end else begin
              timed_out <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: randomized runs against a run-level model,
// scoreboard checked by an independent monitor.
module tb_run_monitor;

  localparam int NC = 4;
  localparam int XL = 16;
  localparam int CW = 8;
  localparam int RC = 4;
  localparam int TO = 200;
  localparam int SAT = 255;

  typedef struct {
    int          cyc;
    int          ret;
    bit          tout;
    int          idx;
    logic [15:0] res;
  } exp_t;

  logic           clk = 0;
  logic           resetn;
  logic           start;
  logic [NC-1:0]  trap;
  logic [NC-1:0]  step;
  logic [NC*XL-1:0] result;
  logic [NC-1:0]  core_resetn;
  logic           busy;
  logic           done;
  logic           timed_out;
  logic [1:0]     trap_core;
  logic [XL-1:0]  trap_result;
  logic [CW-1:0]  cycle_cnt;
  logic [CW-1:0]  retire_cnt;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   rq[$];
  bit   cr_q = 0;
  bit   done_q = 0;

  run_monitor #(
    .NCORES(NC), .XLEN(XL), .CNT_W(CW),
    .RESET_CYCLES(RC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .trap(trap), .step(step), .result(result),
    .core_resetn(core_resetn), .busy(busy), .done(done),
    .timed_out(timed_out), .trap_core(trap_core),
    .trap_result(trap_result), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_core_resetn"}, 64'(core_resetn), 0);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_done"}, 64'(done), 0);
    chk({nm, "_timed_out"}, 64'(timed_out), 0);
    chk({nm, "_trap_core"}, 64'(trap_core), 0);
    chk({nm, "_trap_result"}, 64'(trap_result), 0);
    chk({nm, "_cycle_cnt"}, 64'(cycle_cnt), 0);
    chk({nm, "_retire_cnt"}, 64'(retire_cnt), 0);
  endtask

  // Monitor: reset-release timing and end-of-run results.
  always @(negedge clk) begin
    if (core_resetn[0] && !cr_q) begin
      if (rq.size() == 0) chk("unexpected_release", 1, 0);
      else chk("release_cycle", 64'(cyc), 64'(rq.pop_front()));
      chk("release_all_cores", 64'(core_resetn), 64'hF);
    end
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
        chk("retire_cnt", 64'(retire_cnt), 64'(e.ret));
        chk("timed_out", 64'(timed_out), 64'(e.tout));
        chk("trap_core", 64'(trap_core), 64'(e.idx));
        chk("trap_result", 64'(trap_result), 64'(e.res));
        chk("done_core_resetn", 64'(core_resetn), 0);
        chk("done_busy", 64'(busy), 0);
      end
    end
    cr_q = core_resetn[0];
    done_q = done;
  end

  // k < 0 means no trap (run ends by timeout).
  task automatic run(input int k, input logic [3:0] tv,
                     input bit rnd, input logic [3:0] spat,
                     input bit fixres, input int abort_at);
    int          n;
    int          sum;
    int          lo;
    int          e0;
    exp_t        e;
    logic [3:0]  st[$];
    logic [15:0] r[4];
    n = (k >= 0) ? k + 1 : TO;
    sum = 0;
    for (int j = 0; j < n; j++) begin
      logic [3:0] s;
      s = rnd ? 4'($urandom) : spat;
      st.push_back(s);
      sum += $countones(s);
    end
    lo = 0;
    for (int i = 3; i >= 0; i--) if (tv[i]) lo = i;
    for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
    if (fixres) begin
      r[1] = 16'hAAAA;
      r[3] = 16'hBBBB;
    end
    e.cyc  = n > SAT ? SAT : n;
    e.ret  = sum > SAT ? SAT : sum;
    e.tout = (k < 0);
    e.idx  = (k < 0) ? 0 : lo;
    e.res  = (k < 0) ? 16'h0 : r[lo];
    if (abort_at < 0) sb.push_back(e);
    start = 1;
    @(posedge clk); #1;
    e0 = cyc;
    start = 0;
    rq.push_back(e0 + RC);
    chk("restart_busy", 64'(busy), 1);
    chk("restart_done", 64'(done), 0);
    chk("restart_cycle_cnt", 64'(cycle_cnt), 0);
    chk("restart_retire_cnt", 64'(retire_cnt), 0);
    chk("restart_timed_out", 64'(timed_out), 0);
    chk("restart_trap_result", 64'(trap_result), 0);
    // Junk during the reset phase must be ignored.
    trap = 4'($urandom) | 4'b0001;
    step = 4'($urandom);
    start = 1;
    repeat (RC) @(posedge clk);
    #1;
    start = 0;
    for (int j = 0; j < n; j++) begin
      if (j == abort_at) begin
        resetn = 0;
        #1;
        chk_idle("async_reset");
        @(posedge clk); #1;
        resetn = 1;
        step = 0;
        trap = 0;
        cr_q = 0;
        return;
      end
      step = st[j];
      trap = (j == k) ? tv : 4'b0;
      result = (j == k) ? {r[3], r[2], r[1], r[0]}
                        : {$urandom, $urandom};
      if (j == n - 1) start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    step = 0;
    trap = 0;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 0;
    start  = 0;
    trap   = 0;
    step   = 0;
    result = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    resetn = 1;
    repeat (6) @(posedge clk);
    #1;
    run(99, 4'b0001, 0, 4'b0001, 0, -1);
    run(37, 4'b1010, 1, 4'b0000, 1, -1);
    run(-1, 4'b0000, 1, 4'b0000, 0, -1);
    run(TO - 1, 4'b0100, 1, 4'b0000, 0, -1);
    run(9, 4'b1000, 0, 4'b1111, 0, -1);
    run(79, 4'b0010, 0, 4'b1111, 0, -1);
    run(150, 4'b0001, 1, 4'b0000, 0, 30);
    trap = 4'hF;
    step = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_trap_busy", 64'(busy), 0);
    chk("idle_trap_done", 64'(done), 0);
    chk("idle_trap_core_resetn", 64'(core_resetn), 0);
    chk("idle_trap_cycle_cnt", 64'(cycle_cnt), 0);
    trap = 0;
    step = 0;
    for (int i = 0; i < 8; i++) begin
      int k;
      k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run(k, 4'($urandom_range(1, 15)), 1, 4'b0000,
          bit'($urandom_range(0, 1)), -1);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("pending_done_events", 64'(sb.size()), 0);
    chk("pending_release_events", 64'(rq.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
